// File: rtl/id_scoreboard_stall.sv
// Decode-stage register scoreboard and interlock.
// Each register has a small countdown giving the number of cycles left
// before its in-flight result can be forwarded. A decoding instruction
// stalls while any register it reads is still counting (RAW), or while
// its destination would be written by an older, slower producer after
// its own result (WAW). Stall and hold cycles send a bubble to ID/EX.
//
// Countdown timing: a producer issued with latency L is forwardable to
// the instruction decoding L cycles later. The register is therefore
// loaded with L-1 on the issue edge, so a consumer directly behind a
// latency-1 producer sees zero and issues without stalling.
module id_scoreboard_stall #(
    parameter int NUM_REGS   = 128,
    parameter int REG_ADDR_W = 7,
    parameter int LAT_W      = 3,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_ra_i,
    input  logic                  id_ra_used_i,
    input  logic [REG_ADDR_W-1:0] id_rb_i,
    input  logic                  id_rb_used_i,
    input  logic [REG_ADDR_W-1:0] id_rc_i,
    input  logic                  id_rc_used_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_rt_used_i,
    input  logic                  id_regwrite_i,
    input  logic [LAT_W-1:0]      id_lat_i,
    input  logic                  ex_hold_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  bubble_o,
    output logic                  issue_o,
    output logic                  pending_any_o,
    output logic [CNT_W-1:0]      stall_count_o
);

    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;
    logic             raw;
    logic             waw;
    logic             haz;

    // Hazard detection against the current (pre-load) countdowns, so an
    // instruction never stalls on the counter it is about to load itself.
    always_comb begin
        raw = (id_ra_used_i && (cnt_q[id_ra_i] != '0))
           || (id_rb_used_i && (cnt_q[id_rb_i] != '0))
           || (id_rc_used_i && (cnt_q[id_rc_i] != '0))
           || (id_rt_used_i && (cnt_q[id_rt_i] != '0));
        waw = id_regwrite_i && (cnt_q[id_rt_i] > id_lat_i);
        haz = id_valid_i && !flush_i && (raw || waw);
    end

    // Pipeline control: a flush drops the instruction (no stall), a hold
    // freezes everything, and reset forces a bubble with no stall.
    always_comb begin
        issue_o  = id_valid_i && !flush_i && !haz && !ex_hold_i && !reset;
        stall_o  = !reset && (ex_hold_i || haz);
        bubble_o = reset || (!ex_hold_i && !issue_o);
    end

    // Any register still counting down.
    always_comb begin
        pending_any_o = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (cnt_q[r] != '0) begin
                pending_any_o = 1'b1;
            end
        end
    end

    // Next countdowns and stall counter; a hold freezes both.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!ex_hold_i && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
        if (issue_o && id_regwrite_i && (id_lat_i != '0)) begin
            cnt_d[id_rt_i] = id_lat_i - LAT_W'(1);
        end
        stall_count_d = stall_count_q;
        if (haz && !ex_hold_i && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_id_scoreboard_stall.sv
// Directed bench for id_scoreboard_stall: a per-cycle table of inputs and
// expected outputs, followed by hand-written long-latency sequences.
module tb_id_scoreboard_stall;

    logic        clk;
    logic        reset;
    logic        id_valid_i;
    logic [6:0]  id_ra_i;
    logic        id_ra_used_i;
    logic [6:0]  id_rb_i;
    logic        id_rb_used_i;
    logic [6:0]  id_rc_i;
    logic        id_rc_used_i;
    logic [6:0]  id_rt_i;
    logic        id_rt_used_i;
    logic        id_regwrite_i;
    logic [2:0]  id_lat_i;
    logic        ex_hold_i;
    logic        flush_i;
    logic        stall_o;
    logic        bubble_o;
    logic        issue_o;
    logic        pending_any_o;
    logic [31:0] stall_count_o;

    int checks = 0;
    int errors = 0;

    id_scoreboard_stall dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid_i    (id_valid_i),
        .id_ra_i       (id_ra_i),
        .id_ra_used_i  (id_ra_used_i),
        .id_rb_i       (id_rb_i),
        .id_rb_used_i  (id_rb_used_i),
        .id_rc_i       (id_rc_i),
        .id_rc_used_i  (id_rc_used_i),
        .id_rt_i       (id_rt_i),
        .id_rt_used_i  (id_rt_used_i),
        .id_regwrite_i (id_regwrite_i),
        .id_lat_i      (id_lat_i),
        .ex_hold_i     (ex_hold_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .bubble_o      (bubble_o),
        .issue_o       (issue_o),
        .pending_any_o (pending_any_o),
        .stall_count_o (stall_count_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [6:0]  ra;
        logic        rau;
        logic [6:0]  rb;
        logic        rbu;
        logic [6:0]  rc;
        logic        rcu;
        logic [6:0]  rt;
        logic        rtu;
        logic        rw;
        logic [2:0]  lat;
        logic        hold;
        logic        fl;
        logic        es;
        logic        eb;
        logic        ei;
        logic        ep;
        logic [31:0] ec;
    } vec_t;

    vec_t vecs[$];

    // Input builders
    function automatic vec_t f_idle();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic vec_t f_rst();
        vec_t v = f_idle();
        v.rst = 1'b1;
        return v;
    endfunction

    function automatic vec_t f_prod(input int rt, input int lat);
        vec_t v = f_idle();
        v.vld = 1'b1; v.rt = 7'(rt); v.rw = 1'b1; v.lat = 3'(lat);
        return v;
    endfunction

    function automatic vec_t f_ra(input int r);
        vec_t v = f_idle();
        v.vld = 1'b1; v.ra = 7'(r); v.rau = 1'b1;
        return v;
    endfunction

    function automatic vec_t f_rb(input int r);
        vec_t v = f_idle();
        v.vld = 1'b1; v.rb = 7'(r); v.rbu = 1'b1;
        return v;
    endfunction

    function automatic vec_t f_rc(input int r);
        vec_t v = f_idle();
        v.vld = 1'b1; v.rc = 7'(r); v.rcu = 1'b1;
        return v;
    endfunction

    // Store: reads rt as data, writes nothing (latency field is noise).
    function automatic vec_t f_store(input int rt);
        vec_t v = f_idle();
        v.vld = 1'b1; v.rt = 7'(rt); v.rtu = 1'b1; v.rw = 1'b0; v.lat = 3'd5;
        v.ra = 7'd1; v.rau = 1'b1;
        return v;
    endfunction

    task automatic add(input vec_t v, input logic s, input logic b, input logic i,
                       input logic p, input int c);
        v.es = s; v.eb = b; v.ei = i; v.ep = p; v.ec = 32'(c);
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        id_valid_i    = v.vld;
        id_ra_i       = v.ra;
        id_ra_used_i  = v.rau;
        id_rb_i       = v.rb;
        id_rb_used_i  = v.rbu;
        id_rc_i       = v.rc;
        id_rc_used_i  = v.rcu;
        id_rt_i       = v.rt;
        id_rt_used_i  = v.rtu;
        id_regwrite_i = v.rw;
        id_lat_i      = v.lat;
        ex_hold_i     = v.hold;
        flush_i       = v.fl;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Apply one vector for one cycle and check it away from the active edge.
    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
    endtask

    vec_t t;

    initial begin
        drive(f_rst());
        @(posedge clk);
        @(posedge clk);

        //                    stall bub iss pend count
        // Producer rt=5 lat=4, consumer ra=5 stalls three cycles.
        add(f_rst(),          0, 1, 0, 0, 0);
        add(f_prod(5, 4),     0, 0, 1, 0, 0);
        add(f_ra(5),          1, 1, 0, 1, 0);
        add(f_ra(5),          1, 1, 0, 1, 1);
        add(f_ra(5),          1, 1, 0, 1, 2);
        add(f_ra(5),          0, 0, 1, 0, 3);
        add(f_idle(),         0, 1, 0, 0, 3);
        // Latency 1: back-to-back without stall.
        add(f_rst(),          0, 1, 0, 0, 3);
        add(f_prod(9, 1),     0, 0, 1, 0, 0);
        add(f_rb(9),          0, 0, 1, 0, 0);
        add(f_idle(),         0, 1, 0, 0, 0);
        // WAW: rt=3 lat=6 then writer rt=3 lat=2, then a reader of r3.
        add(f_prod(3, 6),     0, 0, 1, 0, 0);
        add(f_prod(3, 2),     1, 1, 0, 1, 0);
        add(f_prod(3, 2),     1, 1, 0, 1, 1);
        add(f_prod(3, 2),     1, 1, 0, 1, 2);
        add(f_prod(3, 2),     0, 0, 1, 1, 3);
        add(f_ra(3),          1, 1, 0, 1, 3);
        add(f_ra(3),          0, 0, 1, 0, 4);
        // Hold during an rc stall freezes countdown and stall counter.
        add(f_rst(),          0, 1, 0, 0, 4);
        add(f_prod(20, 5),    0, 0, 1, 0, 0);
        add(f_rc(20),         1, 1, 0, 1, 0);
        t = f_rc(20); t.hold = 1'b1;
        add(t,                1, 0, 0, 1, 1);
        add(t,                1, 0, 0, 1, 1);
        add(f_rc(20),         1, 1, 0, 1, 1);
        add(f_rc(20),         1, 1, 0, 1, 2);
        add(f_rc(20),         1, 1, 0, 1, 3);
        add(f_rc(20),         0, 0, 1, 0, 4);
        // Flush of a stalled consumer; producer still drains on schedule.
        add(f_prod(11, 4),    0, 0, 1, 0, 4);
        add(f_ra(11),         1, 1, 0, 1, 4);
        t = f_ra(11); t.fl = 1'b1;
        add(t,                0, 1, 0, 1, 5);
        add(f_idle(),         0, 1, 0, 1, 5);
        add(f_idle(),         0, 1, 0, 0, 5);
        // Store behind rt=7 lat=3, reset pulse mid-stall.
        add(f_prod(7, 3),     0, 0, 1, 0, 5);
        add(f_store(7),       1, 1, 0, 1, 5);
        t = f_store(7); t.rst = 1'b1;
        add(t,                0, 1, 0, 1, 6);
        add(f_store(7),       0, 0, 1, 0, 0);
        add(f_idle(),         0, 1, 0, 0, 0);
        // Store behind rt=7 lat=3 without reset: two stalls, sets no counter.
        add(f_prod(7, 3),     0, 0, 1, 0, 0);
        add(f_store(7),       1, 1, 0, 1, 0);
        add(f_store(7),       1, 1, 0, 1, 1);
        add(f_store(7),       0, 0, 1, 0, 2);
        add(f_idle(),         0, 1, 0, 0, 2);
        // Register 0 and self-dependency: ra=rt=0 checked only on old count.
        add(f_prod(0, 2),     0, 0, 1, 0, 2);
        t = f_prod(0, 3); t.ra = 7'd0; t.rau = 1'b1;
        add(t,                1, 1, 0, 1, 2);
        add(t,                0, 0, 1, 0, 3);
        add(f_ra(0),          1, 1, 0, 1, 3);
        add(f_ra(0),          1, 1, 0, 1, 4);
        add(f_ra(0),          0, 0, 1, 0, 5);
        // Invalid slot reading a busy register never stalls.
        add(f_prod(40, 3),    0, 0, 1, 0, 5);
        t = f_ra(40); t.vld = 1'b0;
        add(t,                0, 1, 0, 1, 5);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
            chk($sformatf("v%0d stall_o", i),       32'(stall_o),       32'(vecs[i].es));
            chk($sformatf("v%0d bubble_o", i),      32'(bubble_o),      32'(vecs[i].eb));
            chk($sformatf("v%0d issue_o", i),       32'(issue_o),       32'(vecs[i].ei));
            chk($sformatf("v%0d pending_any_o", i), 32'(pending_any_o), 32'(vecs[i].ep));
            chk($sformatf("v%0d stall_count_o", i), stall_count_o,      vecs[i].ec);
        end

        // Latency 7 producer: consumer waits six cycles, bounded by a budget.
        begin
            int n;
            bit done;
            step(f_rst());
            step(f_prod(100, 7));
            n = 0;
            done = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                step(f_rb(100));
                if (issue_o) done = 1'b1;
                else n++;
            end
            chk("lat7 issued within budget", 32'(done), 32'd1);
            chk("lat7 stall cycles", 32'(n), 32'd6);
            step(f_idle());
            chk("lat7 stall_count_o", stall_count_o, 32'd6);
            chk("lat7 drained", 32'(pending_any_o), 32'd0);
        end

        // Latency 0 write is not tracked: reader issues immediately.
        step(f_prod(50, 0));
        chk("lat0 issue", 32'(issue_o), 32'd1);
        step(f_rc(50));
        chk("lat0 pending", 32'(pending_any_o), 32'd0);
        chk("lat0 reader issue", 32'(issue_o), 32'd1);
        chk("lat0 reader stall", 32'(stall_o), 32'd0);

        // Hold with no hazard: stall, no bubble, no issue, counter unchanged.
        t = f_ra(60); t.hold = 1'b1;
        step(t);
        chk("hold stall_o", 32'(stall_o), 32'd1);
        chk("hold bubble_o", 32'(bubble_o), 32'd0);
        chk("hold issue_o", 32'(issue_o), 32'd0);
        step(f_idle());
        chk("hold stall_count_o", stall_count_o, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
